// File: rtl/mux_2to1_arbiter_if.sv
// Bundle of the two requester handshakes, the registered output handshake
// and the arbiter status signals (sel, busy) for mux_2to1_arbiter.
// slave  : arbiter side (drives ready_a/ready_b, out, out_valid, sel, busy).
// master : environment side (drives requester data/valids and out_ready).
interface mux_2to1_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic             valid_a;
  logic             ready_a;
  logic [WIDTH-1:0] b;
  logic             valid_b;
  logic             ready_b;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             sel;
  logic             busy;

  modport slave (
    input  a, valid_a, b, valid_b, out_ready,
    output ready_a, ready_b, out, out_valid, sel, busy
  );

  modport master (
    output a, valid_a, b, valid_b, out_ready,
    input  ready_a, ready_b, out, out_valid, sel, busy
  );
endinterface

// File: rtl/mux_2to1_arbiter.sv
// mux_2to1_arbiter: round-robin arbiter owning the select of a 2-to-1 data
// mux. One requester is granted at a time for bursts of up to HOLD_MAX beats;
// the selected beat is registered into a single-entry output stage with its
// own valid/ready handshake.
//
// Optional build macro: MUX_ARB_FIXED_PRIO_EN
//   defined   -> no round-robin pointer; an IDLE tie always grants A.
//   undefined -> round-robin pointer decides IDLE ties (default).
module mux_2to1_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_2to1_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic             space_s;
  logic             ready_a_s;
  logic             ready_b_s;
  logic             acc_a_s;
  logic             acc_b_s;
  logic [3:0]       count_inc_s;
  logic             enter_a_s;
  logic             enter_b_s;
  logic             tie_b_s;   // 1: an IDLE tie goes to B

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign tie_b_s = 1'b0;
`else
  logic ptr_q, ptr_d;        // 0: A wins next tie, 1: B wins next tie
  assign tie_b_s = ptr_q;
`endif

  // Output stage can take a beat when empty or being drained this cycle.
  assign space_s     = !out_valid_q | bus.out_ready;
  assign ready_a_s   = (state_q == ST_GRANT_A) & space_s;
  assign ready_b_s   = (state_q == ST_GRANT_B) & space_s;
  assign acc_a_s     = bus.valid_a & ready_a_s;
  assign acc_b_s     = bus.valid_b & ready_b_s;
  assign count_inc_s = count_q + 4'd1;

  assign bus.ready_a   = ready_a_s;
  assign bus.ready_b   = ready_b_s;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != ST_IDLE);

  // Next-state, burst counter, select and output-stage computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sel_d       = sel_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    enter_a_s   = 1'b0;
    enter_b_s   = 1'b0;

    // Output stage: load the accepted beat, else drain on out_ready.
    if (acc_a_s) begin
      out_d       = bus.a;
      out_valid_d = 1'b1;
    end else if (acc_b_s) begin
      out_d       = bus.b;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_a && bus.valid_b) begin
          if (tie_b_s) begin
            enter_b_s = 1'b1;
          end else begin
            enter_a_s = 1'b1;
          end
        end else if (bus.valid_a) begin
          enter_a_s = 1'b1;
        end else if (bus.valid_b) begin
          enter_b_s = 1'b1;
        end else begin
          count_d = 4'd0;
        end
      end

      ST_GRANT_A: begin
        if (acc_a_s) begin
          if (count_inc_s == HOLD_MAX_C) begin
            // Burst limit reached: hand over if B waits, else restart or stop.
            if (bus.valid_b) begin
              enter_b_s = 1'b1;
            end else if (bus.valid_a) begin
              count_d = 4'd0;
            end else begin
              state_d = ST_IDLE;
              count_d = 4'd0;
            end
          end else begin
            count_d = count_inc_s;
          end
        end else if (!bus.valid_a) begin
          // Early release by A.
          if (bus.valid_b) begin
            enter_b_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            count_d = 4'd0;
          end
        end else begin
          // A waiting on backpressure: freeze state and count.
          count_d = count_q;
        end
      end

      ST_GRANT_B: begin
        if (acc_b_s) begin
          if (count_inc_s == HOLD_MAX_C) begin
            if (bus.valid_a) begin
              enter_a_s = 1'b1;
            end else if (bus.valid_b) begin
              count_d = 4'd0;
            end else begin
              state_d = ST_IDLE;
              count_d = 4'd0;
            end
          end else begin
            count_d = count_inc_s;
          end
        end else if (!bus.valid_b) begin
          if (bus.valid_a) begin
            enter_a_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            count_d = 4'd0;
          end
        end else begin
          count_d = count_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = 4'd0;
      end
    endcase

    // Entering a grant always restarts the burst and moves the mux select.
    if (enter_a_s) begin
      state_d = ST_GRANT_A;
      count_d = 4'd0;
      sel_d   = 1'b0;
    end else if (enter_b_s) begin
      state_d = ST_GRANT_B;
      count_d = 4'd0;
      sel_d   = 1'b1;
    end else begin
      sel_d   = sel_q;
    end
  end

  // Arbiter state, burst counter, select and output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 4'd0;
      sel_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifndef MUX_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after granting one requester, favour the other.
  always_comb begin
    if (enter_a_s) begin
      ptr_d = 1'b1;
    end else if (enter_b_s) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register, A favoured out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Scoreboard bench for mux_2to1_arbiter: directed requester queues drive the
// two valid/ready inputs, the expected output order is pushed when stimulus
// is issued, and a separate monitor pops/compares on every consumed beat.
module tb_mux_2to1_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_2to1_arbiter_if #(.WIDTH(4)) bus ();

  mux_2to1_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] expq[$];
  int         pop_cyc[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic sync_ab();
    bus.valid_a = (qa.size() != 0);
    bus.a       = (qa.size() != 0) ? qa[0] : 4'h0;
    bus.valid_b = (qb.size() != 0);
    bus.b       = (qb.size() != 0) ? qb[0] : 4'h0;
  endtask

  // Main process acts 2 time units after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((expq.size() != 0 || qa.size() != 0 || qb.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    chk({name, "_timeout"}, (k < budget) ? 1 : 0, 1);
    step(3);
  endtask

  // Cycle counter for throughput measurements.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester models: pop a beat after a handshake edge, re-present queue heads.
  initial begin : producer
    logic fire_a, fire_b;
    qa.delete();
    qb.delete();
    sync_ab();
    forever begin
      @(posedge clk);
      fire_a = bus.valid_a && bus.ready_a && !reset;
      fire_b = bus.valid_b && bus.ready_b && !reset;
      #1;
      if (fire_a && qa.size() != 0) void'(qa.pop_front());
      if (fire_b && qb.size() != 0) void'(qb.pop_front());
      sync_ab();
      #2;
      sync_ab();
    end
  end

  // Monitor: every beat consumed at the next edge is compared with the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!reset && bus.out_valid && bus.out_ready) begin
      pop_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_beat", 32'(bus.out), 16);
      end else begin
        chk("out_beat", 32'(bus.out), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int found;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step(3);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out",       32'(bus.out),       0);
    chk("rst_sel",       32'(bus.sel),       0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_ready_a",   32'(bus.ready_a),   0);
    chk("rst_ready_b",   32'(bus.ready_b),   0);
    reset = 1'b0;
    step(1);
    chk("idle_busy", 32'(bus.busy), 0);

    // Single requester A: 2..9, restart after 4 beats without a bubble.
    base = pop_cyc.size();
    for (int d = 2; d <= 9; d++) begin
      qa.push_back(4'(d));
      expq.push_back(4'(d));
    end
    step(1);
    chk("lat_ready_a",   32'(bus.ready_a),   1);
    chk("lat_sel",       32'(bus.sel),       0);
    chk("lat_busy",      32'(bus.busy),      1);
    chk("lat_out_valid", 32'(bus.out_valid), 0);
    step(1);
    chk("lat2_out_valid", 32'(bus.out_valid), 1);
    chk("lat2_out",       32'(bus.out),       2);
    drain("single", 40);
    chk("single_pops", pop_cyc.size() - base, 8);
    chk("single_span", pop_cyc[$] - pop_cyc[base], 7);

    // Reset mid-traffic with a beat held in the output stage.
    bus.out_ready = 1'b0;
    qa.push_back(4'hB);
    qa.push_back(4'hC);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step(1);
      if (bus.out_valid) found = 1;
    end
    chk("held_beat_seen", found, 1);
    reset = 1'b1;
    qa.delete();
    step(1);
    chk("mrst_busy",      32'(bus.busy),      0);
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    step(1);
    chk("mrst_out",     32'(bus.out),     0);
    chk("mrst_sel",     32'(bus.sel),     0);
    chk("mrst_ready_a", 32'(bus.ready_a), 0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    step(2);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    // Contention: both valid continuously, A wins first after reset.
    base = pop_cyc.size();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(4'h3);
      qb.push_back(4'hA);
    end
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) begin
        expq.push_back((g % 2 == 0) ? 4'h3 : 4'hA);
      end
    end
    step(1);
    chk("cont_first_sel", 32'(bus.sel), 0);
    drain("contention", 60);
    chk("cont_pops", pop_cyc.size() - base, 16);
    chk("cont_span", pop_cyc[$] - pop_cyc[base], 15);

    // Early release: A drops after 2 beats while B waits.
    base = pop_cyc.size();
    qa.push_back(4'h1);
    qa.push_back(4'h2);
    qb.push_back(4'h7);
    qb.push_back(4'h8);
    qb.push_back(4'h9);
    expq.push_back(4'h1);
    expq.push_back(4'h2);
    expq.push_back(4'h7);
    expq.push_back(4'h8);
    expq.push_back(4'h9);
    drain("early", 40);
    chk("early_span", pop_cyc[$] - pop_cyc[base], 5);

    // Backpressure with 6 held; B arrives during the stall, count must survive.
    for (int d = 4; d <= 8; d++) qa.push_back(4'(d));
    expq.push_back(4'h4);
    expq.push_back(4'h5);
    expq.push_back(4'h6);
    expq.push_back(4'h7);
    expq.push_back(4'hC);
    expq.push_back(4'h8);
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      step(1);
      if (bus.out_valid && bus.out == 4'h6) found = 1;
    end
    chk("bp_six_seen", found, 1);
    bus.out_ready = 1'b0;
    qb.push_back(4'hC);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_out",       32'(bus.out),       6);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_ready_a",   32'(bus.ready_a),   0);
      chk("bp_sel",       32'(bus.sel),       0);
    end
    bus.out_ready = 1'b1;
    drain("backpressure", 40);

    // Ties from IDLE after gaps; reset first so the pointer favours A.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    for (int d = 1; d <= 5; d++) qa.push_back(4'(d));
    qb.push_back(4'h9);
    expq.push_back(4'h1);
    expq.push_back(4'h2);
    expq.push_back(4'h3);
    expq.push_back(4'h4);
    expq.push_back(4'h9);
    expq.push_back(4'h5);
    step(1);
    chk("tie1_sel", 32'(bus.sel), 0);
    drain("tie1", 40);
    step(3);
    qa.push_back(4'h6);
    qb.push_back(4'hE);
`ifdef MUX_ARB_FIXED_PRIO_EN
    expq.push_back(4'h6);
    expq.push_back(4'hE);
    step(1);
    chk("tie2_sel", 32'(bus.sel), 0);
`else
    expq.push_back(4'hE);
    expq.push_back(4'h6);
    step(1);
    chk("tie2_sel", 32'(bus.sel), 1);
`endif
    drain("tie2", 40);
    chk("end_busy", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
